// File: rtl/memarb.sv
// Shares one DDR controller port among N burst clients: port 0 has fixed priority
// with a starvation limit, and ports 1..N-1 are served round-robin, one burst at a time.
module memarb #(
    parameter int N       = 3,
    parameter int MAXHOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      creq,
    input  logic [N-1:0]      cwr,
    input  logic [23*N-1:0]   caddr,
    input  logic [2*N-1:0]    clen,
    input  logic [32*N-1:0]   cwdata,
    output logic [N-1:0]      cack,
    output logic [N-1:0]      cready,
    output logic [31:0]       crdata,
    output logic              mreq,
    output logic              mwr,
    output logic [22:0]       maddr,
    output logic [1:0]        mlen,
    output logic [31:0]       mwdata,
    input  logic              mack,
    input  logic              mready,
    input  logic [31:0]       mrdata
);
    localparam int GW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = $clog2(MAXHOLD + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, BURST} state_t;

    state_t        state, state_nx;
    logic [GW-1:0] g, lastrr, win, rrwin;
    logic [HW-1:0] holdcnt;
    logic [1:0]    beats;
    logic          protoerr;
    logic          others, p0win, rrfound;

    assign others = |creq[N-1:1];
    assign p0win  = creq[0] && !((holdcnt == HW'(MAXHOLD)) && others);
    assign win    = p0win ? '0 : rrwin;

    // Round-robin over ports 1..N-1 only, starting just after the last RR winner.
    always_comb begin
        rrwin   = '0;
        rrfound = 1'b0;
        for (int k = 0; k < N-1; k++) begin
            if (!rrfound && creq[((int'(lastrr) + k) % (N-1)) + 1]) begin
                rrfound = 1'b1;
                rrwin   = GW'(((int'(lastrr) + k) % (N-1)) + 1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|creq)                     state_nx = ISSUE;
            ISSUE:   if (mack)                      state_nx = BURST;
            BURST:   if (mready && beats == 2'd0)   state_nx = IDLE;
            default:                                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            g        <= '0;
            mwr      <= 1'b0;
            maddr    <= '0;
            mlen     <= '0;
            holdcnt  <= '0;
            lastrr   <= GW'(N-1);
            beats    <= '0;
            protoerr <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (|creq) begin
                    g     <= win;
                    mwr   <= cwr[win];
                    maddr <= caddr[23*win +: 23];
                    mlen  <= clen[2*win +: 2];
                    if (win == '0) begin
                        if (others)
                            holdcnt <= (holdcnt == HW'(MAXHOLD)) ? holdcnt : holdcnt + 1'b1;
                        else
                            holdcnt <= '0;
                    end else begin
                        holdcnt <= '0;
                        lastrr  <= win;
                    end
                end
                ISSUE: begin
                    if (mack)   beats    <= mlen;
                    // A data beat before acceptance is a mem protocol error; it is dropped.
                    if (mready) protoerr <= 1'b1;
                end
                BURST: if (mready) beats <= beats - 2'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        cack   = '0;
        cready = '0;
        if (state == ISSUE && mack)   cack[g]   = 1'b1;
        if (state == BURST && mready) cready[g] = 1'b1;
    end

    assign mreq   = (state == ISSUE);
    assign crdata = mrdata;
    assign mwdata = cwdata[32*g +: 32];

endmodule
